counter_sequencer: RTL and testbench

Command-driven controller for `universal_counter`. It accepts one command at a time over a valid/ready handshake and drives the counter's `clear`, `mode`, `incr` and `pause` inputs to carry it out. It also watches the counter's `count` output to implement seek-to-value. It sits between a host or testbench sequencer and a single counter instance, so stimulus can be written as a command stream instead of raw pin timing.

---
 rtl/counter_pkg.sv | 30 +++
 rtl/counter_sequencer.sv | 157 +++++++++++++++
 tb/tb_counter_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencer: op/mode encodings,
// controller states and the per-mode counter modulus.
package counter_pkg;

    localparam logic [1:0] OP_CLR  = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_HOLD = 2'd2;
    localparam logic [1:0] OP_SEEK = 2'd3;

    localparam logic MODE_BIN = 1'b0;
    localparam logic MODE_BCD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_RUN,
        ST_HOLD,
        ST_SEEK,
        ST_DONE
    } state_e;

    // Number of distinct counter values in the given mode.
    function automatic int unsigned modulus(
        input logic        mode,
        input int unsigned width
    );
        return (mode == MODE_BIN) ? (32'd1 << width) : 32'd10;
    endfunction

endpackage

// File: rtl/counter_sequencer.sv
// Command-driven controller for universal_counter: turns CLR/RUN/HOLD/SEEK
// commands into clear/mode/incr/pause pin activity, one command at a time.
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ARG_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_mode,
    input  logic             cmd_incr,
    input  logic [ARG_W-1:0] cmd_arg,
    input  logic [WIDTH-1:0] count,
    output logic             cnt_clear,
    output logic             cnt_mode,
    output logic             cnt_incr,
    output logic             cnt_pause,
    output logic             done,
    output logic             err
);

    state_e           state_q;
    logic             ready_q;
    logic             pause_q;
    logic             clr_q;
    logic             done_q;
    logic             err_q;
    logic             mode_q;
    logic             incr_q;
    logic [ARG_W-1:0] rem_q;
    logic [ARG_W-1:0] tgt_q;
    logic             seek_hit;
    logic             arg_zero;
    logic             tgt_bad;

    assign seek_hit = (32'(count) == 32'(tgt_q));
    assign arg_zero = (cmd_arg == '0);
    assign tgt_bad  = (32'(cmd_arg) >= modulus(cmd_mode, WIDTH));

    // Output drive: system clear zeroes the counter directly; SEEK pauses
    // combinationally on a match so the target is never overshot.
    always_comb begin
        cmd_ready = ready_q & ~clear;
        cnt_clear = clear | clr_q;
        cnt_mode  = mode_q;
        cnt_incr  = incr_q;
        cnt_pause = (state_q == ST_SEEK) ? seek_hit : pause_q;
        done      = done_q;
        err       = err_q;
    end

    // Controller FSM with registered outputs set alongside each transition.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            pause_q <= 1'b1;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mode_q  <= MODE_BIN;
            incr_q  <= 1'b1;
            rem_q   <= '0;
            tgt_q   <= '0;
        end else begin
            ready_q <= 1'b0;
            pause_q <= 1'b1;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (cmd_valid) begin
                        ready_q <= 1'b0;
                        mode_q  <= cmd_mode;
                        incr_q  <= cmd_incr;
                        rem_q   <= cmd_arg;
                        tgt_q   <= cmd_arg;
                        unique case (cmd_op)
                            OP_CLR: begin
                                state_q <= ST_CLR;
                                clr_q   <= 1'b1;
                            end
                            OP_RUN: begin
                                if (arg_zero) begin
                                    state_q <= ST_DONE;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= ST_RUN;
                                    pause_q <= 1'b0;
                                end
                            end
                            OP_HOLD: begin
                                if (arg_zero) begin
                                    state_q <= ST_DONE;
                                    done_q  <= 1'b1;
                                end else begin
                                    state_q <= ST_HOLD;
                                end
                            end
                            OP_SEEK: begin
                                if (tgt_bad) begin
                                    state_q <= ST_DONE;
                                    done_q  <= 1'b1;
                                    err_q   <= 1'b1;
                                end else begin
                                    state_q <= ST_SEEK;
                                end
                            end
                        endcase
                    end
                end
                ST_CLR: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_RUN: begin
                    if (rem_q == ARG_W'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        rem_q   <= rem_q - ARG_W'(1);
                        pause_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (rem_q == ARG_W'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        rem_q <= rem_q - ARG_W'(1);
                    end
                end
                ST_SEEK: begin
                    if (seek_hit) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a behavioural counter closes the loop and a
// command-level model predicts every output cycle by cycle.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       clear;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_mode;
    logic       cmd_incr;
    logic [7:0] cmd_arg;
    logic [3:0] count;
    logic       cnt_clear;
    logic       cnt_mode;
    logic       cnt_incr;
    logic       cnt_pause;
    logic       done;
    logic       err;

    typedef struct {
        bit rdy;
        bit pau;
        bit clr;
        bit dn;
        bit er;
        int cnt;
    } rec_t;

    rec_t exp_q[$];
    int   m_count  = 0;
    bit   exp_mode = 1'b0;
    bit   exp_incr = 1'b1;
    int   checks   = 0;
    int   fails    = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    int   last_lat = -1;
    int   last_err = 0;

    counter_sequencer #(.WIDTH(4), .ARG_W(8)) dut (
        .clk(clk),
        .clear(clear),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_mode(cmd_mode),
        .cmd_incr(cmd_incr),
        .cmd_arg(cmd_arg),
        .count(count),
        .cnt_clear(cnt_clear),
        .cnt_mode(cnt_mode),
        .cnt_incr(cnt_incr),
        .cnt_pause(cnt_pause),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for universal_counter: system clear is asynchronous,
    // the controller's clear request acts on the clock edge.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) count <= 4'd0;
        else if (cnt_clear) count <= 4'd0;
        else if (!cnt_pause) begin
            if (cnt_mode)
                count <= cnt_incr ? ((count == 4'd9) ? 4'd0 : count + 4'd1)
                                  : ((count == 4'd0) ? 4'd9 : count - 4'd1);
            else
                count <= cnt_incr ? count + 4'd1 : count - 4'd1;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    function automatic int stepn(int c, int n, bit md, bit up);
        int m;
        m = md ? 10 : 16;
        if (up) return (c + n) % m;
        return ((c - n) % m + m) % m;
    endfunction

    function automatic void push(bit rdy, bit pau, bit clr,
                                 bit dn, bit er, int cnt);
        rec_t r;
        r.rdy = rdy; r.pau = pau; r.clr = clr;
        r.dn = dn; r.er = er; r.cnt = cnt;
        exp_q.push_back(r);
    endfunction

    // One compare per cycle against the model's expected record.
    always @(negedge clk) begin
        rec_t r;
        if (clear) begin
            r.rdy = 0; r.pau = 1; r.clr = 1; r.dn = 0; r.er = 0; r.cnt = 0;
        end else if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
        end else begin
            r.rdy = 1; r.pau = 1; r.clr = 0; r.dn = 0; r.er = 0;
            r.cnt = m_count;
        end
        chk("cmd_ready", int'(cmd_ready), int'(r.rdy));
        chk("cnt_pause", int'(cnt_pause), int'(r.pau));
        chk("cnt_clear", int'(cnt_clear), int'(r.clr));
        chk("done", int'(done), int'(r.dn));
        chk("err", int'(err), int'(r.er));
        chk("count", int'(count), r.cnt);
        chk("cnt_mode", int'(cnt_mode), int'(exp_mode));
        chk("cnt_incr", int'(cnt_incr), int'(exp_incr));
        if (done && !clear) begin
            last_lat = cyc - acc_cyc;
            last_err = int'(err);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            fails++;
            $display("FAIL wait_idle: got timeout expected drained queue");
        end
    endtask

    task automatic issue(input logic [1:0] op, input bit md,
                         input bit up, input int arg);
        int c, m, s;
        wait_idle();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mode  = md;
        cmd_incr  = up;
        cmd_arg   = 8'(arg);
        @(posedge clk);
        #1;
        acc_cyc   = cyc - 1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_mode  = 1'($urandom_range(0, 1));
        cmd_incr  = 1'($urandom_range(0, 1));
        cmd_arg   = 8'($urandom_range(0, 255));
        exp_mode  = md;
        exp_incr  = up;
        c = m_count;
        m = md ? 10 : 16;
        case (op)
            2'd0: begin
                push(0, 1, 1, 0, 0, c);
                push(0, 1, 0, 1, 0, 0);
                m_count = 0;
            end
            2'd1: begin
                for (int k = 1; k <= arg; k++)
                    push(0, 0, 0, 0, 0, stepn(c, k - 1, md, up));
                m_count = stepn(c, arg, md, up);
                push(0, 1, 0, 1, 0, m_count);
            end
            2'd2: begin
                for (int k = 1; k <= arg; k++)
                    push(0, 1, 0, 0, 0, c);
                push(0, 1, 0, 1, 0, c);
            end
            default: begin
                if (arg >= m) begin
                    push(0, 1, 0, 1, 1, c);
                end else begin
                    s = up ? (arg - c + m) % m : (c - arg + m) % m;
                    for (int k = 1; k <= s; k++)
                        push(0, 0, 0, 0, 0, stepn(c, k - 1, md, up));
                    push(0, 1, 0, 0, 0, arg);
                    push(0, 1, 0, 1, 0, arg);
                    m_count = arg;
                end
            end
        endcase
    endtask

    task automatic reset_dut(input int n);
        clear = 1'b1;
        exp_q.delete();
        m_count  = 0;
        exp_mode = 1'b0;
        exp_incr = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    initial begin
        int op, arg;
        bit md, up;
        clear     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_mode  = 1'b0;
        cmd_incr  = 1'b1;
        cmd_arg   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        clear = 1'b0;

        issue(2'd0, 0, 1, 0);
        wait_idle();
        chk("clr_lat", last_lat, 2);
        chk("clr_cnt", int'(count), 0);
        chk("clr_err", last_err, 0);

        issue(2'd1, 0, 1, 3);
        issue(2'd1, 0, 1, 5);
        wait_idle();
        chk("run5_lat", last_lat, 6);
        chk("run5_cnt", int'(count), 8);
        issue(2'd1, 0, 1, 10);
        wait_idle();
        chk("run10_wrap", int'(count), 2);

        issue(2'd1, 1, 0, 1);
        issue(2'd1, 1, 0, 3);
        wait_idle();
        chk("bcd_dn_cnt", int'(count), 8);
        chk("bcd_dn_lat", last_lat, 4);

        issue(2'd1, 1, 0, 1);
        issue(2'd2, 1, 0, 4);
        wait_idle();
        chk("hold_lat", last_lat, 5);
        chk("hold_cnt", int'(count), 7);

        issue(2'd0, 0, 1, 0);
        issue(2'd1, 0, 1, 2);
        issue(2'd3, 0, 1, 11);
        wait_idle();
        chk("seek_lat", last_lat, 11);
        chk("seek_cnt", int'(count), 11);
        issue(2'd3, 0, 1, 11);
        wait_idle();
        chk("seek0_lat", last_lat, 2);
        issue(2'd3, 1, 1, 12);
        wait_idle();
        chk("seek_bad_err", last_err, 1);
        chk("seek_bad_lat", last_lat, 1);
        chk("seek_bad_cnt", int'(count), 11);

        issue(2'd1, 0, 1, 8);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_cnt", int'(count), 14);
        last_lat = -1;
        clear = 1'b1;
        exp_q.delete();
        m_count  = 0;
        exp_mode = 1'b0;
        exp_incr = 1'b1;
        #1;
        chk("rst_cnt", int'(count), 0);
        chk("rst_ready", int'(cmd_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        clear = 1'b0;
        #1;
        chk("rel_ready", int'(cmd_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        chk("no_done", last_lat, -1);
        issue(2'd1, 0, 1, 2);
        wait_idle();
        chk("post_rst_cnt", int'(count), 2);

        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 3);
            md = 1'($urandom_range(0, 1));
            up = 1'($urandom_range(0, 1));
            arg = (op == 3) ? $urandom_range(0, 17) : $urandom_range(0, 20);
            if (md && m_count >= 10) md = 1'b0;
            wait_idle();
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 24) == 0) begin
                issue(2'd1, md, up, 20);
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1;
                reset_dut($urandom_range(1, 3));
            end else begin
                issue(2'(op), md, up, arg);
            end
        end
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
